// File: rtl/rv_lsu_if.sv
// Data-bus bundle between the load/store unit (master) and memory (slave).
// The request side is held stable until ack, error or timeout.
interface rv_lsu_if #(
    parameter int unsigned XLEN = 32
);
    logic              req;
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN/8-1:0] sel;
    logic [XLEN-1:0]   wdata;
    logic              ack;
    logic              err;
    logic [XLEN-1:0]   rdata;

    modport master (
        output req, we, addr, sel, wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  req, we, addr, sel, wdata,
        output ack, err, rdata
    );
endinterface

// File: rtl/rv_lsu.sv
// Handshaked memory stage: one instruction in flight, aligned req/ack bus access,
// sign/zero-extended loads, misaligned/bus-error/timeout exceptions, 1-cycle pass-through.
module rv_lsu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [2:0]      i_funct3,
    input  logic            i_mem_read,
    input  logic            i_mem_write,
    input  logic [4:0]      i_rd,
    input  logic            i_reg_write,
    rv_lsu_if.master        io_bus,
    output logic            o_valid,
    output logic [4:0]      o_rd,
    output logic            o_reg_write,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_exc,
    output logic [1:0]      o_exc_cause
);
    localparam int unsigned NumBytes = XLEN / 8;
    localparam int unsigned OffW     = $clog2(NumBytes);
    localparam int unsigned CntW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e                r_state, w_state_next;
    logic                  w_accept, w_is_mem, w_misal, w_tmo, w_fail;
    logic [OffW-1:0]       w_off;
    logic [2:0]            w_bmask;
    logic [7:0]            w_lanes;
    logic [NumBytes-1:0]   w_sel;
    logic [XLEN-1:0]       w_wdata, w_shifted, w_load;

    logic                  r_pt_valid, r_kill, r_is_load, r_uns;
    logic [1:0]            r_size;
    logic [OffW-1:0]       r_off;
    logic [CntW-1:0]       r_cnt;
    logic [4:0]            r_rd;
    logic                  r_reg_write, r_exc;
    logic [1:0]            r_cause;
    logic [XLEN-1:0]       r_rdata;
    logic                  r_bus_we;
    logic [XLEN-1:0]       r_bus_addr, r_bus_wdata;
    logic [NumBytes-1:0]   r_bus_sel;

    // Access decode for the instruction being offered.
    always_comb begin
        w_is_mem = i_mem_read | i_mem_write;
        w_off    = i_addr[OffW-1:0];
        w_misal  = 1'b0;
        w_bmask  = 3'd0;
        w_lanes  = 8'h01;
        unique case (i_funct3[1:0])
            2'b00: begin w_bmask = 3'd0; w_lanes = 8'h01; w_misal = 1'b0; end
            2'b01: begin w_bmask = 3'd1; w_lanes = 8'h03; w_misal = i_addr[0]; end
            2'b10: begin w_bmask = 3'd3; w_lanes = 8'h0F; w_misal = |i_addr[1:0]; end
            default: begin
                w_bmask = 3'd7;
                w_lanes = 8'hFF;
                w_misal = (XLEN == 32) ? 1'b1 : |i_addr[2:0];
            end
        endcase
        if (i_mem_write && i_funct3[2]) w_misal = 1'b1;
        w_sel   = NumBytes'(w_lanes) << w_off;
        w_wdata = '0;
        for (int j = 0; j < NumBytes; j++) begin
            w_wdata[8*j +: 8] = i_wdata[8*(j & int'(w_bmask)) +: 8];
        end
    end

    // Load extraction from the captured offset/size of the in-flight access.
    always_comb begin
        w_shifted = io_bus.rdata >> {r_off, 3'b000};
        unique case (r_size)
            2'b00:   w_load = r_uns ? XLEN'(w_shifted[7:0])  : XLEN'($signed(w_shifted[7:0]));
            2'b01:   w_load = r_uns ? XLEN'(w_shifted[15:0]) : XLEN'($signed(w_shifted[15:0]));
            2'b10:   w_load = r_uns ? XLEN'(w_shifted[31:0]) : XLEN'($signed(w_shifted[31:0]));
            default: w_load = w_shifted;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= StIdle;
        else            r_state <= w_state_next;
    end

    always_comb begin
        o_ready  = (r_state != StBus);
        o_valid  = r_pt_valid | ((r_state == StResp) & ~r_kill);
        w_accept = i_valid & o_ready & ~i_flush;
        // Counter holds completed wait cycles, so the request lasts exactly TIMEOUT cycles.
        w_tmo    = (TIMEOUT != 0) && (r_cnt == CntW'(TIMEOUT - 1));
        w_fail   = io_bus.err | w_tmo;
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StResp: begin
                w_state_next = (w_accept & w_is_mem & ~w_misal) ? StBus : StIdle;
            end
            StBus: begin
                if (io_bus.ack | w_fail) w_state_next = StResp;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pt_valid  <= 1'b0;
            r_kill      <= 1'b0;
            r_is_load   <= 1'b0;
            r_uns       <= 1'b0;
            r_size      <= 2'b00;
            r_off       <= '0;
            r_cnt       <= '0;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_exc       <= 1'b0;
            r_cause     <= 2'b00;
            r_rdata     <= '0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_sel   <= '0;
        end else begin
            r_pt_valid <= w_accept & ~(w_is_mem & ~w_misal);
            if (w_accept) begin
                r_rd        <= i_rd;
                r_rdata     <= i_addr;
                r_exc       <= w_is_mem & w_misal;
                r_cause     <= (w_is_mem & w_misal) ? (i_mem_write ? 2'b10 : 2'b01) : 2'b00;
                r_reg_write <= i_reg_write & ~i_mem_write & ~(w_is_mem & w_misal);
                r_is_load   <= i_mem_read & ~i_mem_write;
                r_uns       <= i_funct3[2];
                r_size      <= i_funct3[1:0];
                r_off       <= w_off;
                if (w_is_mem & ~w_misal) begin
                    r_bus_we    <= i_mem_write;
                    r_bus_addr  <= {i_addr[XLEN-1:OffW], OffW'(0)};
                    r_bus_sel   <= w_sel;
                    r_bus_wdata <= w_wdata;
                end
            end
            if (r_state == StBus) begin
                r_cnt  <= r_cnt + CntW'(1);
                r_kill <= r_kill | i_flush;
                if (w_fail) begin
                    r_exc       <= 1'b1;
                    r_cause     <= 2'b11;
                    r_reg_write <= 1'b0;
                end else if (io_bus.ack && r_is_load) begin
                    r_rdata <= w_load;
                end
            end else begin
                r_cnt <= '0;
            end
            if (r_state == StResp) r_kill <= 1'b0;
        end
    end

    assign io_bus.req   = (r_state == StBus);
    assign io_bus.we    = r_bus_we;
    assign io_bus.addr  = r_bus_addr;
    assign io_bus.sel   = r_bus_sel;
    assign io_bus.wdata = r_bus_wdata;

    assign o_rd        = r_rd;
    assign o_reg_write = r_reg_write;
    assign o_rdata     = r_rdata;
    assign o_exc       = r_exc;
    assign o_exc_cause = r_cause;
endmodule

// File: tb/tb_rv_lsu.sv
// Bench for rv_lsu: a 32-bit (timeout off) and a 64-bit (TIMEOUT=4) instance driven
// one at a time, checked against an arithmetic model of the access rules.
module tb_rv_lsu;
    localparam int unsigned TO32 = 0;
    localparam int unsigned TO64 = 4;

    typedef struct packed {
        logic        bus;
        logic        bwe;
        logic [63:0] baddr;
        logic [63:0] bsel;
        logic [63:0] bwdata;
        logic [63:0] rdata;
        logic        exc;
        logic [1:0]  cause;
        logic        rw;
    } exp_t;

    logic        clk, rst_n, vld32, vld64, flush, b_ack, b_err, sel64;
    logic [63:0] b_addr, b_wdata, b_rdata;
    logic [2:0]  b_f3;
    logic        b_mr, b_mw, b_rw;
    logic [4:0]  b_rd;

    logic        d32_ready, d32_valid, d32_rw, d32_exc;
    logic [4:0]  d32_rd;
    logic [1:0]  d32_cause;
    logic [31:0] d32_rdata;
    logic        d64_ready, d64_valid, d64_rw, d64_exc;
    logic [4:0]  d64_rd;
    logic [1:0]  d64_cause;
    logic [63:0] d64_rdata;

    logic [63:0] obs_ready, obs_valid, obs_rd, obs_rw, obs_rdata, obs_exc, obs_cause;
    logic [63:0] obs_req, obs_we, obs_addr, obs_sel, obs_wdata;

    int n_total = 0;
    int n_bad   = 0;

    rv_lsu_if #(.XLEN(32)) bus32 ();
    rv_lsu_if #(.XLEN(64)) bus64 ();

    assign bus32.ack   = b_ack;
    assign bus32.err   = b_err;
    assign bus32.rdata = b_rdata[31:0];
    assign bus64.ack   = b_ack;
    assign bus64.err   = b_err;
    assign bus64.rdata = b_rdata;

    rv_lsu #(.XLEN(32), .TIMEOUT(TO32)) u_dut32 (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(vld32), .o_ready(d32_ready),
        .i_flush(flush), .i_addr(b_addr[31:0]), .i_wdata(b_wdata[31:0]), .i_funct3(b_f3),
        .i_mem_read(b_mr), .i_mem_write(b_mw), .i_rd(b_rd), .i_reg_write(b_rw),
        .io_bus(bus32.master), .o_valid(d32_valid), .o_rd(d32_rd), .o_reg_write(d32_rw),
        .o_rdata(d32_rdata), .o_exc(d32_exc), .o_exc_cause(d32_cause)
    );

    rv_lsu #(.XLEN(64), .TIMEOUT(TO64)) u_dut64 (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(vld64), .o_ready(d64_ready),
        .i_flush(flush), .i_addr(b_addr), .i_wdata(b_wdata), .i_funct3(b_f3),
        .i_mem_read(b_mr), .i_mem_write(b_mw), .i_rd(b_rd), .i_reg_write(b_rw),
        .io_bus(bus64.master), .o_valid(d64_valid), .o_rd(d64_rd), .o_reg_write(d64_rw),
        .o_rdata(d64_rdata), .o_exc(d64_exc), .o_exc_cause(d64_cause)
    );

    always_comb begin
        if (sel64) begin
            obs_ready = 64'(d64_ready);  obs_valid = 64'(d64_valid); obs_rd = 64'(d64_rd);
            obs_rw    = 64'(d64_rw);     obs_rdata = d64_rdata;      obs_exc = 64'(d64_exc);
            obs_cause = 64'(d64_cause);  obs_req   = 64'(bus64.req); obs_we = 64'(bus64.we);
            obs_addr  = bus64.addr;      obs_sel   = 64'(bus64.sel); obs_wdata = bus64.wdata;
        end else begin
            obs_ready = 64'(d32_ready);  obs_valid = 64'(d32_valid); obs_rd = 64'(d32_rd);
            obs_rw    = 64'(d32_rw);     obs_rdata = 64'(d32_rdata); obs_exc = 64'(d32_exc);
            obs_cause = 64'(d32_cause);  obs_req   = 64'(bus32.req); obs_we = 64'(bus32.we);
            obs_addr  = 64'(bus32.addr); obs_sel   = 64'(bus32.sel); obs_wdata = 64'(bus32.wdata);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected behaviour from the access rules, independent of cycle timing.
    function automatic exp_t model(input int xl, input logic [63:0] a, input logic [63:0] wd,
                                   input logic [63:0] rdat, input logic [2:0] f,
                                   input logic mr, input logic mw, input logic rw,
                                   input logic fail);
        exp_t        e;
        int          nb, by, off;
        logic [63:0] xm, v, m;
        nb  = xl / 8;
        by  = 1 << f[1:0];
        off = int'(a & 64'(nb - 1));
        xm  = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        e       = '0;
        e.rdata = a & xm;
        e.rw    = rw;
        if (!(mr || mw)) return e;
        if ((by > nb) || (mw && f[2]) || ((a & 64'(by - 1)) != 0)) begin
            e.exc   = 1'b1;
            e.cause = mw ? 2'b10 : 2'b01;
            e.rw    = 1'b0;
            return e;
        end
        e.bus   = 1'b1;
        e.bwe   = mw;
        e.baddr = a & xm & ~64'(nb - 1);
        e.bsel  = ((64'd1 << by) - 64'd1) << off;
        for (int j = 0; j < nb; j++) e.bwdata[8*j +: 8] = wd[8*(j % by) +: 8];
        if (fail) begin
            e.exc   = 1'b1;
            e.cause = 2'b11;
            e.rw    = 1'b0;
            return e;
        end
        if (mw) begin
            e.rw = 1'b0;
        end else begin
            v = (rdat & xm) >> (8 * off);
            if (by < 8) begin
                m = (64'd1 << (8 * by)) - 64'd1;
                v = v & m;
                if (!f[2] && v[8*by-1]) v = v | ~m;
            end
            e.rdata = v & xm;
        end
        return e;
    endfunction

    task automatic drive(input logic [63:0] a, input logic [63:0] wd, input logic [2:0] f,
                         input logic mr, input logic mw, input logic rw, input logic [4:0] rd);
        b_addr = a; b_wdata = wd; b_f3 = f; b_mr = mr; b_mw = mw; b_rw = rw; b_rd = rd;
    endtask

    // kind: 0 ack, 1 err alone, 2 err with ack. A delay past the timeout means no response.
    task automatic run_op(input logic is64, input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] rdat, input logic [2:0] f, input logic mr,
                          input logic mw, input logic rw, input logic [4:0] rd,
                          input int delay, input int kind, input logic fl);
        exp_t e;
        int   to, nreq, exp_nreq;
        logic tmo, exp_valid;
        to       = is64 ? int'(TO64) : int'(TO32);
        tmo      = (to != 0) && (delay >= to);
        exp_nreq = tmo ? to : delay + 1;
        e        = model(is64 ? 64 : 32, a, wd, rdat, f, mr, mw, rw, tmo || (kind != 0));
        @(negedge clk);
        sel64   = is64;
        b_rdata = rdat;
        drive(a, wd, f, mr, mw, rw, rd);
        if (is64) vld64 = 1'b1; else vld32 = 1'b1;
        chk("ready", obs_ready, 64'd1);
        @(posedge clk);
        @(negedge clk);
        vld32 = 1'b0;
        vld64 = 1'b0;
        nreq  = 0;
        while (obs_req == 64'd1 && nreq < 64) begin
            nreq++;
            if (nreq == 1) begin
                chk("bus_addr", obs_addr, e.baddr);
                chk("bus_sel", obs_sel, e.bsel);
                chk("bus_wdata", obs_wdata, e.bwdata);
                chk("bus_we", obs_we, 64'(e.bwe));
            end
            flush = fl && (nreq == 1);
            if (!tmo && (nreq - 1 == delay)) begin
                b_ack = (kind != 1);
                b_err = (kind != 0);
            end else begin
                b_ack = 1'b0;
                b_err = 1'b0;
            end
            @(negedge clk);
        end
        b_ack = 1'b0;
        b_err = 1'b0;
        flush = 1'b0;
        chk("req_cycles", 64'(nreq), e.bus ? 64'(exp_nreq) : 64'd0);
        exp_valid = !(e.bus && fl);
        chk("valid", obs_valid, 64'(exp_valid));
        if (exp_valid) begin
            chk("rd", obs_rd, 64'(rd));
            chk("rdata", obs_rdata, e.rdata);
            chk("exc", obs_exc, 64'(e.exc));
            chk("cause", obs_cause, 64'(e.cause));
            chk("reg_write", obs_rw, 64'(e.rw));
        end
        @(negedge clk);
        chk("valid_drop", obs_valid, 64'd0);
    endtask

    initial begin
        logic [63:0] a;
        logic [2:0]  f;
        logic        is64, mr, mw, fl;
        int          typ, delay, kind, r;

        rst_n = 1'b0; vld32 = 1'b0; vld64 = 1'b0; flush = 1'b0; sel64 = 1'b0;
        b_ack = 1'b0; b_err = 1'b0; b_rdata = '0;
        drive(64'd0, 64'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel64 = s[0];
            #1;
            chk("rst_ready", obs_ready, 64'd1);
            chk("rst_valid", obs_valid, 64'd0);
            chk("rst_req", obs_req, 64'd0);
            chk("rst_we", obs_we, 64'd0);
            chk("rst_sel", obs_sel, 64'd0);
            chk("rst_addr", obs_addr, 64'd0);
            chk("rst_wdata", obs_wdata, 64'd0);
            chk("rst_rdata", obs_rdata, 64'd0);
            chk("rst_exc", obs_exc, 64'd0);
            chk("rst_cause", obs_cause, 64'd0);
            chk("rst_rw", obs_rw, 64'd0);
            chk("rst_rd", obs_rd, 64'd0);
        end
        rst_n = 1'b1;

        // SB, LH/LHU, LD aligned and misaligned, delayed err+ack, timeout, flush in BUS.
        run_op(1'b0, 64'h1003, 64'hA5, 64'h0, 3'b000, 1'b0, 1'b1, 1'b1, 5'd3, 0, 0, 1'b0);
        run_op(1'b0, 64'h2002, 64'h0, 64'h8001_1234, 3'b001, 1'b1, 1'b0, 1'b1, 5'd7, 0, 0, 1'b0);
        run_op(1'b0, 64'h2002, 64'h0, 64'h8001_1234, 3'b101, 1'b1, 1'b0, 1'b1, 5'd8, 1, 0, 1'b0);
        run_op(1'b1, 64'h8, 64'h0, 64'h1122_3344_5566_7788, 3'b011, 1'b1, 1'b0, 1'b1, 5'd9, 0, 0,
               1'b0);
        run_op(1'b1, 64'hC, 64'h0, 64'h0, 3'b011, 1'b1, 1'b0, 1'b1, 5'd10, 0, 0, 1'b0);
        run_op(1'b0, 64'h40, 64'h0, 64'hDEAD_BEEF, 3'b010, 1'b1, 1'b0, 1'b1, 5'd11, 5, 2, 1'b0);
        run_op(1'b1, 64'h40, 64'h0, 64'hDEAD_BEEF, 3'b010, 1'b1, 1'b0, 1'b1, 5'd12, 10, 0, 1'b0);
        run_op(1'b0, 64'h80, 64'h0, 64'h1234_5678, 3'b010, 1'b1, 1'b0, 1'b1, 5'd13, 2, 0, 1'b1);
        run_op(1'b0, 64'h84, 64'h55, 64'h0, 3'b010, 1'b0, 1'b1, 1'b0, 5'd14, 0, 0, 1'b0);

        // Flush coincident with an offered load in IDLE: nothing accepted.
        @(negedge clk);
        sel64 = 1'b0;
        drive(64'h100, 64'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd1);
        vld32 = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld32 = 1'b0;
        flush = 1'b0;
        chk("flush_idle_valid", obs_valid, 64'd0);
        chk("flush_idle_req", obs_req, 64'd0);
        @(negedge clk);
        chk("flush_idle_req2", obs_req, 64'd0);

        // Three back-to-back pass-through ops.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("b2b_valid", obs_valid, 64'd1);
                chk("b2b_rdata", obs_rdata, 64'h100 * 64'(i));
                chk("b2b_rd", obs_rd, 64'(i + 19));
            end
            drive(64'h100 * 64'(i + 1), 64'h0, 3'b000, 1'b0, 1'b0, 1'b1, 5'(i + 20));
            vld32 = 1'b1;
        end
        @(negedge clk);
        vld32 = 1'b0;
        chk("b2b_valid", obs_valid, 64'd1);
        chk("b2b_rdata", obs_rdata, 64'h300);
        chk("b2b_rd", obs_rd, 64'd22);
        @(negedge clk);
        chk("b2b_valid_drop", obs_valid, 64'd0);

        // Reset while a request is outstanding, then a late ack.
        @(negedge clk);
        sel64 = 1'b1;
        drive(64'h10, 64'h77, 3'b011, 1'b0, 1'b1, 1'b0, 5'd4);
        vld64 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld64 = 1'b0;
        chk("mid_req", obs_req, 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_req", obs_req, 64'd0);
        chk("mid_rst_valid", obs_valid, 64'd0);
        chk("mid_rst_sel", obs_sel, 64'd0);
        chk("mid_rst_addr", obs_addr, 64'd0);
        chk("mid_rst_wdata", obs_wdata, 64'd0);
        chk("mid_rst_we", obs_we, 64'd0);
        chk("mid_rst_rdata", obs_rdata, 64'd0);
        rst_n = 1'b1;
        b_ack = 1'b1;
        @(negedge clk);
        b_ack = 1'b0;
        chk("late_ack_valid", obs_valid, 64'd0);
        chk("late_ack_req", obs_req, 64'd0);
        @(negedge clk);
        chk("late_ack_valid2", obs_valid, 64'd0);

        // Randomized mix across both widths.
        for (int n = 0; n < 150; n++) begin
            is64 = 1'($urandom_range(0, 1));
            typ  = $urandom_range(0, 2);
            mr   = (typ == 1);
            mw   = (typ == 2);
            f    = 3'($urandom_range(0, 7));
            a    = is64 ? {32'($urandom), 32'($urandom)} : 64'($urandom);
            if ($urandom_range(0, 1) == 1) a = a & ~64'h7;
            delay = $urandom_range(0, 6);
            if (is64 && delay == int'(TO64) - 1) delay = int'(TO64) + 1;
            r    = $urandom_range(0, 9);
            kind = (r < 8) ? 0 : ((r == 8) ? 1 : 2);
            fl   = ($urandom_range(0, 9) == 0);
            run_op(is64, a, {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)}, f,
                   mr, mw, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), delay, kind, fl);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/rv_lsu.md
# rv_lsu

Parametrised load/store unit that replaces the fixed 32-bit memory pipeline register with a handshaked, multi-cycle memory stage. It sits between the execute stage and writeback. It accepts one instruction at a time, drives a req/ack data bus with aligned address, byte-lane selects and replicated store data, and returns a zero- or sign-extended load result. Misaligned accesses, bus errors and bus timeouts are reported as exceptions. Non-memory instructions pass through with one cycle of latency.

## Interface
- XLEN, 32, data/address width; legal values 32 or 64.
- TIMEOUT, 255, bus wait limit in cycles while `o_bus_req` is high; 0 disables the timeout.
- i_clk  in  1  sole clock; all logic on the rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage accepts an instruction this cycle.
- i_flush  in  1  kill the instruction in flight and any instruction being offered.
- i_addr  in  XLEN  effective address (ALU result).
- i_wdata  in  XLEN  store data (rs2).
- i_funct3  in  3  access size/sign.
- i_mem_read / i_mem_write  in  1 each  load / store.
- i_rd  in  5  destination register.
- i_reg_write  in  1  writeback enable.
- o_bus_req  out  1  bus request; held until ack, error or timeout.
- o_bus_we  out  1  write strobe.
- o_bus_addr  out  XLEN  address with low log2(XLEN/8) bits forced to 0.
- o_bus_sel  out  XLEN/8  byte-lane enables.
- o_bus_wdata  out  XLEN  lane-replicated store data.
- i_bus_ack  in  1  transfer complete; `i_bus_rdata` is valid in the same cycle.
- i_bus_err  in  1  transfer failed; only sampled while `o_bus_req` is high.
- i_bus_rdata  in  XLEN  read data.
- o_valid  out  1  one-cycle pulse; writeback fields are valid.
- o_rd  out  5  destination register.
- o_reg_write  out  1  writeback enable; forced to 0 when `o_exc` is 1.
- o_rdata  out  XLEN  load result when the instruction is a load; otherwise the registered `i_addr`.
- o_exc  out  1  exception flag.
- o_exc_cause  out  2  01 = misaligned load, 10 = misaligned store, 11 = bus error or timeout.

## Operation
- States:
  - IDLE: nothing in flight, or a pass-through/exception result is presenting.
  - BUS: request outstanding.
  - RESP: memory result presenting.
- `o_ready` = state != BUS.
- Accept = `i_valid & o_ready & ~i_flush`. Accepted fields are captured into registers.
- Size decode from `funct3[1:0]`: 00 byte, 01 half, 10 word, 11 double.
  - Double is legal only when XLEN=64. With XLEN=32 it is treated as misaligned.
  - `funct3[2]` = 1 means zero-extend, otherwise sign-extend.
  - A store with `funct3[2]` = 1 is misaligned.
- Misaligned check: address low bits must be 0 modulo the access size.
- Accepted misaligned memory op:
  - No bus request is made and the state stays IDLE.
  - Next cycle: `o_valid`=1, `o_exc`=1, cause 01 or 10, `o_reg_write`=0.
- Accepted aligned memory op: go to BUS and assert `o_bus_req`.
  - `o_bus_sel` = (2^bytes − 1) shifted left by `addr` modulo (XLEN/8).
  - `o_bus_wdata` = the low `bytes` of `i_wdata` replicated across XLEN.
- Non-memory op: no state change. `o_valid`=1 next cycle with `o_rdata` = captured address and `o_rd`/`o_reg_write` passed through.
- BUS → RESP on `i_bus_ack`, `i_bus_err`, or timeout counter == TIMEOUT.
  - The counter clears on entry to BUS.
  - If ack and err are asserted in the same cycle, err wins.
- Load extract: shift `i_bus_rdata` right by 8×(addr offset), then sign- or zero-extend from the access size. The result is registered on ack.
- RESP lasts one cycle with `o_valid`=1, then returns to IDLE.
  - A new instruction may be accepted during RESP.
  - Error or timeout gives `o_exc`=1, cause 11.
  - A store returns `o_reg_write`=0.
- Flush:
  - In IDLE or RESP: blocks acceptance and suppresses any `o_valid` due next cycle.
  - In BUS: the request still runs to completion, but the RESP cycle gives `o_valid`=0. The flush is remembered in a sticky kill bit, cleared on RESP exit.

## Timing
- Reset: state IDLE. `o_valid`, `o_bus_req`, `o_bus_we`, `o_exc`, `o_reg_write` = 0. `o_bus_sel`, `o_bus_addr`, `o_bus_wdata`, `o_rdata`, `o_rd`, `o_exc_cause` = 0. The timeout counter and kill bit are 0.
- Reset mid-transaction: `o_bus_req` drops the next cycle and any late `i_bus_ack` is ignored.
- Pass-through or misaligned: accept in cycle N, `o_valid` in cycle N+1.
- Aligned memory op: accept in cycle N, `o_bus_req` high from N+1. If the ack arrives in cycle M, `o_bus_req` is low in M+1 and `o_valid` is high in M+1. Minimum latency is 2 cycles.
- Bus outputs are stable while `o_bus_req` is high.
- Back-to-back pass-through ops achieve 1 per cycle. Memory ops achieve at best 1 per 2 cycles.
- Timeout fires after TIMEOUT cycles with `o_bus_req` high and no ack or error.

## Test plan
- Reset, then XLEN=32, SB of 0x000000A5 to 0x1003, ack on the first req cycle → `o_bus_addr`=0x1000, `o_bus_sel`=1000, `o_bus_wdata`=0xA5A5A5A5, `o_valid` 2 cycles after accept, `o_reg_write`=0.
- LH from 0x2002, rdata 0x8001_1234 → `o_rdata`=0xFFFF8001. LHU gives 0x00008001.
- XLEN=64, LD from 0x8 → `o_bus_sel`=0xFF. LD from 0xC → misaligned, cause 01, no `o_bus_req`, `o_valid` the next cycle.
- Bus wait: ack delayed 5 cycles, then `i_bus_err` and `i_bus_ack` together → `o_exc`=1, cause 11, `o_reg_write`=0. With TIMEOUT=4 and no ack → exception after 4 req cycles.
- `i_flush` during BUS → the request still completes and `o_valid` stays 0. Flush coincident with `i_valid` in IDLE → nothing accepted.
- Three back-to-back ALU ops → three consecutive `o_valid` pulses with `o_rdata` equal to each address. `i_reset_n`=0 mid-BUS → `o_bus_req` low the next cycle and all outputs 0.
